// File: rtl/microcode_loader_pkg.sv
// Shared constants and state encoding for the microcode loader.
package microcode_loader_pkg;

    localparam int unsigned PCB_WIDTH  = 24;
    localparam int unsigned DEPTH_LOG2 = 6;
    localparam int unsigned NBYTES     = (PCB_WIDTH + 7) / 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StWrite   = 2'd2,
        StFinish  = 2'd3
    } state_e;

endpackage

// File: rtl/microcode_loader_if.sv
// Byte stream handshake feeding the loader (MSB of each word first).
interface microcode_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/microcode_byte_packer.sv
// Shifts stream bytes into a control word; flags the byte that completes it.
module microcode_byte_packer
    import microcode_loader_pkg::*;
#(
    parameter int unsigned Width  = PCB_WIDTH,
    parameter int unsigned NBytes = (Width + 7) / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [7:0]       data_i,
    output logic [Width-1:0] word_o,
    output logic             last_o
);

    localparam int unsigned IdxW = $clog2(NBytes + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

    logic [IdxW-1:0]  idx_q, idx_d;
    logic [Width-1:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        last_o = en_i && (idx_q == LastIdx);
        if (clr_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (en_i) begin
            // Excess high bits of the first byte fall off the top.
            word_d = {word_q[Width-9:0], data_i};
            idx_d  = idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/microcode_loader.sv
// Streams bytes into microcode RAM words: one write per packed word, with
// completion pulse, sticky error and running XOR checksum.
module microcode_loader
    import microcode_loader_pkg::*;
#(
    parameter int unsigned PcbWidth  = PCB_WIDTH,
    parameter int unsigned DepthLog2 = DEPTH_LOG2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DepthLog2-1:0] base_i,
    input  logic [DepthLog2:0]   count_i,
    input  logic                 abort_i,
    microcode_loader_if.slave    s_if,
    output logic                 we_o,
    output logic [DepthLog2-1:0] waddr_o,
    output logic [PcbWidth-1:0]  wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [PcbWidth-1:0]  chk_o
);

    localparam logic [DepthLog2+1:0] Entries = (DepthLog2 + 2)'(2 ** DepthLog2);

    state_e               state_q, state_d;
    logic [DepthLog2-1:0] addr_q, addr_d;
    logic [DepthLog2:0]   rem_q, rem_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;
    logic [PcbWidth-1:0]  chk_q, chk_d;

    logic                 pk_clr, pk_en, pk_last, write;
    logic [PcbWidth-1:0]  pk_word;
    logic                 range_err;

    assign range_err = ({2'b00, base_i} + {1'b0, count_i}) > Entries;

    microcode_byte_packer #(
        .Width (PcbWidth)
    ) u_packer (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .clr_i  (pk_clr),
        .en_i   (pk_en),
        .data_i (s_if.s_data),
        .word_o (pk_word),
        .last_o (pk_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        done_d  = 1'b0;
        chk_d   = chk_q;
        pk_clr  = 1'b0;
        pk_en   = 1'b0;
        write   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (range_err) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        chk_d = '0;
                        if (count_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            addr_d  = base_i;
                            rem_d   = count_i;
                            pk_clr  = 1'b1;
                            state_d = StCollect;
                        end
                    end
                end
            end
            StCollect: begin
                if (abort_i) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    pk_clr  = 1'b1;
                    state_d = StIdle;
                end else begin
                    pk_en = s_if.s_valid;
                    if (pk_last) state_d = StWrite;
                end
            end
            StWrite: begin
                if (abort_i) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    pk_clr  = 1'b1;
                    state_d = StIdle;
                end else begin
                    write   = 1'b1;
                    chk_d   = chk_q ^ pk_word;
                    // Counter may wrap to 0 after address 63; it is never used then.
                    addr_d  = addr_q + DepthLog2'(1);
                    rem_d   = rem_q - (DepthLog2 + 1)'(1);
                    pk_clr  = 1'b1;
                    state_d = (rem_q == (DepthLog2 + 1)'(1)) ? StFinish : StCollect;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            done_q  <= done_d;
            chk_q   <= chk_d;
        end
    end

    assign s_if.s_ready = (state_q == StCollect);
    assign we_o         = write;
    assign waddr_o      = write ? addr_q : '0;
    assign wdata_o      = write ? pk_word : '0;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q || (state_q == StFinish);
    assign err_o        = err_q;
    assign chk_o        = chk_q;

endmodule

// File: tb/tb_microcode_loader.sv
// Randomised bench for microcode_loader with a transaction-level model.
module tb_microcode_loader;
    import microcode_loader_pkg::*;

    localparam int W  = PCB_WIDTH;
    localparam int NB = NBYTES;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    microcode_loader_if sif ();

    logic         start, abort;
    logic [5:0]   base;
    logic [6:0]   count;
    logic         we, busy, done, err;
    logic [5:0]   waddr;
    logic [W-1:0] wdata, chk;

    microcode_loader dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start),
        .base_i  (base),
        .count_i (count),
        .abort_i (abort),
        .s_if    (sif.slave),
        .we_o    (we),
        .waddr_o (waddr),
        .wdata_o (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .err_o   (err),
        .chk_o   (chk)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_xfer = 0;
    logic [7:0]   byteq[$];
    logic [5:0]   la[$];
    logic [W-1:0] ld[$];
    int           lc[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: a load is a sequence of words; each word needs NB accepted bytes,
    // then one write cycle. Finishing and error/abort each produce one done cycle.
    bit           m_load, m_full, m_fin, m_dpend, m_err, dp;
    int           m_nb, m_left;
    logic [5:0]   m_addr;
    logic [W-1:0] m_acc, m_chk;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_load = 0; m_full = 0; m_fin = 0; m_dpend = 0; m_err = 0;
            m_nb = 0; m_left = 0; m_addr = '0; m_acc = '0; m_chk = '0;
        end else begin
            dp = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (!m_load) begin
                if (start) begin
                    if (int'(base) + int'(count) > 64) begin
                        m_err = 1; dp = 1;
                    end else begin
                        m_err = 0; m_chk = '0;
                        if (count == 0) dp = 1;
                        else begin
                            m_load = 1; m_addr = base; m_left = int'(count);
                            m_nb = 0; m_acc = '0; m_full = 0;
                        end
                    end
                end
            end else if (abort) begin
                m_err = 1; dp = 1; m_load = 0; m_full = 0; m_nb = 0;
            end else if (m_full) begin
                m_chk = m_chk ^ m_acc;
                m_addr = m_addr + 6'd1;
                m_left--;
                m_full = 0; m_nb = 0;
                if (m_left == 0) begin
                    m_load = 0; m_fin = 1;
                end
            end else if (sif.s_valid) begin
                m_acc = W'((m_acc << 8) | W'(sif.s_data));
                m_nb++;
                if (m_nb == NB) m_full = 1;
            end
            m_dpend = dp;
        end
    end

    always @(negedge clk) begin
        logic ewe;
        if (rst_n) begin
            ewe = m_load && m_full && !abort;
            check("ready", sif.s_ready, m_load && !m_full);
            check("we", we, ewe);
            check("waddr", waddr, ewe ? m_addr : 6'd0);
            check("wdata", wdata, ewe ? m_acc : '0);
            check("busy", busy, m_load || m_fin);
            check("done", done, m_fin || m_dpend);
            check("err", err, m_err);
            check("chk", chk, m_chk);
            if (we) begin
                la.push_back(waddr); ld.push_back(wdata); lc.push_back(cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        la.delete(); ld.delete(); lc.delete();
    endtask

    task automatic do_start(input logic [5:0] b, input logic [6:0] c, input logic ab);
        start = 1'b1; base = b; count = c; abort = ab;
        tick();
        start = 1'b0; abort = 1'b0;
    endtask

    // mode 0: valid always; 1: valid every other cycle; 2: random valid + stray starts
    task automatic stream(input int mode, input int abort_at);
        int  n = 0;
        int  guard = 0;
        bit  tog = 1'b1;
        bit  fired = 1'b0;
        bit  x;
        while ((m_load || m_fin) && guard < 3000) begin
            if (byteq.size() == 0) byteq.push_back(8'($urandom));
            sif.s_data = byteq[0];
            case (mode)
                0: sif.s_valid = 1'b1;
                1: begin sif.s_valid = tog; tog = !tog; end
                default: sif.s_valid = 1'($urandom);
            endcase
            abort = 1'b0;
            if (abort_at >= 0 && n == abort_at && !fired) begin
                abort = 1'b1; fired = 1'b1;
            end
            start = 1'b0;
            if (mode == 2 && sif.s_ready && ($urandom % 8 == 0)) begin
                start = 1'b1; base = 6'($urandom); count = 7'($urandom_range(0, 64));
            end
            x = sif.s_valid && sif.s_ready && !abort;
            if (x) last_xfer = cyc;
            tick();
            if (x) begin
                void'(byteq.pop_front());
                n++;
            end
            guard++;
        end
        sif.s_valid = 1'b0; abort = 1'b0; start = 1'b0;
        if (guard >= 3000) check("timeout", 1, 0);
    endtask

    initial begin
        int d0;
        int g;
        start = 0; abort = 0; base = 0; count = 0;
        sif.s_data = 0; sif.s_valid = 0;
        #22;
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_chk", chk, 0);
        check("rst_ready", sif.s_ready, 0);
        rst_n = 1'b1;
        tick();

        // Two words at 5..6
        clear_log(); d0 = done_cnt;
        byteq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        do_start(6'd5, 7'd2, 1'b0);
        stream(0, -1);
        tick();
        check("t1_nwr", la.size(), 2);
        if (la.size() == 2) begin
            check("t1_a0", la[0], 5);  check("t1_d0", ld[0], 32'hA1B2C3);
            check("t1_a1", la[1], 6);  check("t1_d1", ld[1], 32'hD4E5F6);
        end
        check("t1_chk", chk, 32'h755735);
        check("t1_err", err, 0);
        check("t1_done", done_cnt - d0, 1);

        // Range error, then exact fit ending at 63
        clear_log();
        do_start(6'd60, 7'd5, 1'b0);
        check("t2_err", err, 1);
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        tick();
        check("t2_done_off", done, 0);
        check("t2_nwr", la.size(), 0);
        do_start(6'd60, 7'd4, 1'b0);
        check("t2_errclr", err, 0);
        stream(2, -1);
        tick();
        check("t2_nwr4", la.size(), 4);
        for (int i = 0; i < 4 && i < la.size(); i++) check("t2_addr", la[i], 60 + i);

        // Zero-length load
        clear_log();
        do_start(6'd9, 7'd0, 1'b0);
        check("t3_done", done, 1);
        check("t3_ready", sif.s_ready, 0);
        check("t3_chk", chk, 0);
        tick();
        check("t3_nwr", la.size(), 0);

        // Valid toggling for one word
        clear_log();
        byteq = '{8'h11, 8'h22, 8'h33};
        do_start(6'd33, 7'd1, 1'b0);
        stream(1, -1);
        check("t4_nwr", la.size(), 1);
        if (la.size() == 1) begin
            check("t4_data", ld[0], 32'h112233);
            check("t4_lat", lc[0], last_xfer + 1);
        end

        // Abort after two bytes of word 2 of 3
        clear_log(); d0 = done_cnt;
        byteq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        do_start(6'd10, 7'd3, 1'b0);
        stream(0, 5);
        tick();
        check("t5_nwr", la.size(), 1);
        if (la.size() == 1) check("t5_data", ld[0], 32'h010203);
        check("t5_err", err, 1);
        check("t5_busy", busy, 0);
        check("t5_done", done_cnt - d0, 1);
        do_start(6'd0, 7'd1, 1'b0);
        check("t5_restart", busy, 1);
        stream(0, -1);

        // Reset pulled during a write cycle
        clear_log();
        do_start(6'd20, 7'd2, 1'b0);
        sif.s_valid = 1'b1;
        g = 0;
        while (!we && g < 20) begin
            sif.s_data = 8'($urandom);
            tick();
            g++;
        end
        check("t6_saw_we", we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_we", we, 0);
        check("t6_waddr", waddr, 0);
        check("t6_wdata", wdata, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", sif.s_ready, 0);
        check("t6_chk", chk, 0);
        tick();
        rst_n = 1'b1;
        clear_log();
        repeat (10) tick();
        check("t6_nwr", la.size(), 0);
        check("t6_idle", busy, 0);
        sif.s_valid = 1'b0;

        // Random loads
        for (int k = 0; k < 40; k++) begin
            logic [6:0] c;
            c = 7'($urandom_range(0, 8));
            if ($urandom % 5 == 0) c = 7'($urandom_range(0, 64));
            do_start(6'($urandom), c, ($urandom % 6 == 0));
            stream(2, ($urandom % 3 == 0) ? int'($urandom_range(0, int'(c) * NB)) : -1);
            abort = 1'($urandom);
            tick();
            abort = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
